// File: rtl/rib_pkg.sv
// rib_pkg: shared RIB bus widths and slave response-queue sizing.
package rib_pkg;
    localparam int RIB_DW = 32;
    localparam int RIB_AW = 32;
    localparam int RIB_SW = 4;
    localparam int RIB_SLV_SEL_W = 4;
    localparam int RIB_RSP_FIFO_DEPTH = 2;
endpackage

// File: rtl/rib_rsp_fifo.sv
// rib_rsp_fifo: small synchronous FIFO holding RIB responses the master has not yet taken.
module rib_rsp_fifo
    import rib_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [RIB_DW-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [RIB_DW-1:0] head
);
    localparam int PW = $clog2(RIB_RSP_FIFO_DEPTH);

    logic [RIB_DW-1:0] mem [RIB_RSP_FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    assign full  = count == (PW+1)'(RIB_RSP_FIFO_DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/rib_sram_slave.sv
// rib_sram_slave: RIB slave endpoint driving a 1-cycle-latency single-port SRAM,
// with up to two outstanding requests and an in-order response queue.
module rib_sram_slave
    import rib_pkg::*;
#(
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIB_AW-1:0] addr_i,
    input  logic [RIB_DW-1:0] data_i,
    input  logic [RIB_SW-1:0] sel_i,
    input  logic              req_vld_i,
    input  logic              rsp_rdy_i,
    input  logic              we_i,
    output logic              req_rdy_o,
    output logic              rsp_vld_o,
    output logic [RIB_DW-1:0] data_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RIB_SW-1:0] ram_be_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [RIB_DW-1:0] ram_wdata_o,
    input  logic [RIB_DW-1:0] ram_rdata_i
);
    localparam int OFFSET_W = RIB_AW - RIB_SLV_SEL_W;

    logic [1:0]        cnt;
    logic              inflight_vld, inflight_we;
    logic              acc, pop, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [RIB_DW-1:0] rsp_word, fifo_head;
    logic              unused_addr;

    assign unused_addr = ^{addr_i[RIB_AW-1:OFFSET_W], addr_i[OFFSET_W-1:AW+2], addr_i[1:0], fifo_full};

    assign req_rdy_o   = cnt < 2'd2;
    assign acc         = req_vld_i & req_rdy_o;
    assign ram_en_o    = acc;
    assign ram_we_o    = acc & we_i;
    assign ram_be_o    = we_i ? sel_i : '1;
    assign ram_addr_o  = addr_i[AW+1:2];
    assign ram_wdata_o = data_i;

    // Write responses and idle cycles carry zero rather than stale SRAM output.
    assign rsp_word  = (inflight_vld & ~inflight_we) ? ram_rdata_i : '0;
    assign rsp_vld_o = ~fifo_empty | inflight_vld;
    assign data_o    = fifo_empty ? rsp_word : fifo_head;
    assign pop       = rsp_vld_o & rsp_rdy_i;
    assign fifo_pop  = pop & ~fifo_empty;
    assign fifo_push = inflight_vld & ~(pop & fifo_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            inflight_vld <= 1'b0;
            inflight_we  <= 1'b0;
        end else begin
            cnt          <= cnt + 2'(acc) - 2'(pop);
            inflight_vld <= acc;
            inflight_we  <= acc & we_i;
        end
    end

    rib_rsp_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rsp_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );
endmodule

// File: tb/tb_rib_sram_slave.sv
// tb_rib_sram_slave: directed vector bench for rib_sram_slave with a behavioural SRAM.
module tb_rib_sram_slave;
    localparam int DEPTH = 4096;
    localparam int AW = 12;

    logic clk = 0, rst = 1;
    logic [31:0] addr_i = 0, data_i = 0, data_o, ram_wdata_o, ram_rdata_i = 0;
    logic [3:0] sel_i = 0, ram_be_o;
    logic req_vld_i = 0, rsp_rdy_i = 0, we_i = 0;
    logic req_rdy_o, rsp_vld_o, ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] mem [DEPTH];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rib_sram_slave #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .req_vld_i(req_vld_i), .rsp_rdy_i(rsp_rdy_i), .we_i(we_i),
        .req_rdy_o(req_rdy_o), .rsp_vld_o(rsp_vld_o), .data_o(data_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= mem[ram_addr_o];
            end
        end
    end

    typedef struct {
        logic vld, we;
        logic [31:0] addr, data;
        logic [3:0] sel;
        logic rdy;
        logic x_req_rdy, x_en, x_we;
        logic [3:0] x_be;
        logic [11:0] x_addr;
        logic x_rsp_vld;
        logic [31:0] x_data;
    } vec_t;

    vec_t tbl [15];
    vec_t bp [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #2;
        req_vld_i = v.vld; we_i = v.we; addr_i = v.addr; data_i = v.data; sel_i = v.sel; rsp_rdy_i = v.rdy;
        #2;
        chk({tag, " req_rdy"}, 32'(req_rdy_o), 32'(v.x_req_rdy));
        chk({tag, " ram_en"}, 32'(ram_en_o), 32'(v.x_en));
        chk({tag, " ram_we"}, 32'(ram_we_o), 32'(v.x_we));
        chk({tag, " rsp_vld"}, 32'(rsp_vld_o), 32'(v.x_rsp_vld));
        chk({tag, " data_o"}, data_o, v.x_data);
        if (v.x_en) begin
            chk({tag, " ram_be"}, 32'(ram_be_o), 32'(v.x_be));
            chk({tag, " ram_addr"}, 32'(ram_addr_o), 32'(v.x_addr));
            if (v.x_we) chk({tag, " ram_wdata"}, ram_wdata_o, v.data);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        //          vld we addr          data           sel   rdy  rrdy en we be    addr  rv data
        tbl[0]  = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 0, 32'h0};
        tbl[1]  = '{1, 1, 32'h10,       32'hA5A5_1234, 4'hF, 1,   1,   1, 1, 4'hF, 12'd4, 0, 32'h0};
        tbl[2]  = '{1, 0, 32'h10,       32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd4, 1, 32'h0};
        tbl[3]  = '{1, 1, 32'h10,       32'h0000_7700, 4'h2, 1,   1,   1, 1, 4'h2, 12'd4, 1, 32'hA5A5_1234};
        tbl[4]  = '{1, 0, 32'h10,       32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd4, 1, 32'h0};
        tbl[5]  = '{1, 0, 32'h0,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd0, 1, 32'hA5A5_7734};
        tbl[6]  = '{1, 0, 32'h4,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd1, 1, 32'h1000_0000};
        tbl[7]  = '{1, 0, 32'h8,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd2, 1, 32'h1000_0001};
        tbl[8]  = '{1, 0, 32'hC,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd3, 1, 32'h1000_0002};
        tbl[9]  = '{1, 0, 32'h0000_4012, 32'h0,        4'h0, 1,   1,   1, 0, 4'hF, 12'd4, 1, 32'h1000_0003};
        tbl[10] = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 1, 32'hA5A5_7734};
        tbl[11] = '{1, 1, 32'h0,        32'hFFFF_FFFF, 4'h0, 1,   1,   1, 1, 4'h0, 12'd0, 0, 32'h0};
        tbl[12] = '{1, 0, 32'h0,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd0, 1, 32'h0};
        tbl[13] = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 1, 32'h1000_0000};
        tbl[14] = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 0, 32'h0};
        // Back-pressure: A, B accepted, C stalls until a pop frees a slot.
        bp[0]   = '{1, 0, 32'h0,        32'h0,         4'h0, 0,   1,   1, 0, 4'hF, 12'd0, 0, 32'h0};
        bp[1]   = '{1, 0, 32'h4,        32'h0,         4'h0, 0,   1,   1, 0, 4'hF, 12'd1, 1, 32'h1000_0000};
        bp[2]   = '{1, 0, 32'h8,        32'h0,         4'h0, 0,   0,   0, 0, 4'h0, 12'd0, 1, 32'h1000_0000};
        bp[3]   = '{1, 0, 32'h8,        32'h0,         4'h0, 0,   0,   0, 0, 4'h0, 12'd0, 1, 32'h1000_0000};
        bp[4]   = '{1, 0, 32'h8,        32'h0,         4'h0, 1,   0,   0, 0, 4'h0, 12'd0, 1, 32'h1000_0000};
        bp[5]   = '{1, 0, 32'h8,        32'h0,         4'h0, 1,   1,   1, 0, 4'hF, 12'd2, 1, 32'h1000_0001};
        bp[6]   = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 1, 32'h1000_0002};
        bp[7]   = '{0, 0, 32'h0,        32'h0,         4'h0, 1,   1,   0, 0, 4'h0, 12'd0, 0, 32'h0};

        #23 rst = 0;
        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 8; i++) step(bp[i], $sformatf("bp%0d", i));

        step('{1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 1, 0, 4'hF, 12'd4, 0, 32'h0}, "rs0");
        step('{1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 0, 4'hF, 12'd0, 1, 32'hA5A5_7734}, "rs1");
        @(posedge clk);
        #1 req_vld_i = 0;
        chk("rs_full req_rdy", 32'(req_rdy_o), 32'h0);
        #2 rst = 1;
        #1;
        chk("async rsp_vld", 32'(rsp_vld_o), 32'h0);
        chk("async req_rdy", 32'(req_rdy_o), 32'h1);
        chk("async data_o", data_o, 32'h0);
        repeat (2) @(posedge clk);
        #5 rst = 0;
        step('{1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 1, 0, 4'hF, 12'd4, 0, 32'h0}, "post0");
        step('{0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0, 4'h0, 12'd0, 1, 32'hA5A5_7734}, "post1");
        step('{0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0, 4'h0, 12'd0, 0, 32'h0}, "post2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
